// File: rtl/mano_mem_loader.sv
// Boot-time program loader for the 4096x16 main memory: parses a byte-stream header and writes big-endian words.
// Optional checksum byte after the payload is enabled with LOADER_CHECKSUM_EN.
module mano_mem_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done,
`ifdef LOADER_CHECKSUM_EN
    output logic              chk_err,
`endif
    output logic [12:0]       words_loaded
);

    localparam int unsigned CNT_W = 13;
    localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_HI,
        S_A_LO,
        S_N_HI,
        S_N_LO,
        S_D_HI,
        S_D_LO,
        S_WR,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state, state_next;
    logic              ready_next, busy_next, done_next;
    logic [7:0]        hi_byte, lo_byte;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_sat;
    logic [15:0]       hdr_count;
    logic              accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept    = byte_valid & byte_ready;
    assign hdr_count = {hi_byte, byte_in};
    assign count_sat = (hdr_count > MAX_W16) ? CNT_W'(MAX_WORDS) : CNT_W'(hdr_count);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and registered status decode
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE: if (start)  state_next = S_A_HI;
            S_A_HI:         if (accept) state_next = S_A_LO;
            S_A_LO:         if (accept) state_next = S_N_HI;
            S_N_HI:         if (accept) state_next = S_N_LO;
            S_N_LO:         if (accept) state_next = (count_sat == '0) ? S_TAIL : S_D_HI;
            S_D_HI:         if (accept) state_next = S_D_LO;
            S_D_LO:         if (accept) state_next = S_WR;
            S_WR:           state_next = (count == CNT_W'(1)) ? S_TAIL : S_D_HI;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:          if (accept) state_next = S_DONE;
`endif
            default:        state_next = S_IDLE;
        endcase

        ready_next = !(state_next == S_IDLE || state_next == S_WR || state_next == S_DONE);
        busy_next  = !(state_next == S_IDLE || state_next == S_DONE);
        done_next  = (state_next == S_DONE);
    end

    // Datapath: header capture, word assembly, address/count bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_ready   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
            hi_byte      <= '0;
            lo_byte      <= '0;
            cur_addr     <= '0;
            count        <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
            chk_err      <= 1'b0;
`endif
        end else begin
            byte_ready <= ready_next;
            busy       <= busy_next;
            done       <= done_next;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum         <= '0;
                        chk_err      <= 1'b0;
`endif
                    end
                end
                S_A_HI, S_N_HI: if (accept) hi_byte <= byte_in;
                S_A_LO:         if (accept) cur_addr <= ADDR_W'({hi_byte, byte_in});
                S_N_LO:         if (accept) count <= count_sat;
                S_D_HI: begin
                    if (accept) begin
                        hi_byte <= byte_in;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ byte_in;
`endif
                    end
                end
                S_D_LO: begin
                    if (accept) begin
                        lo_byte <= byte_in;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ byte_in;
`endif
                    end
                end
                S_WR: begin
                    cur_addr     <= cur_addr + ADDR_W'(1);
                    count        <= count - CNT_W'(1);
                    words_loaded <= words_loaded + CNT_W'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK:          if (accept) chk_err <= (byte_in != csum);
`endif
                default: ;
            endcase
        end
    end

    // Memory port mux: loader owns the port while busy, CPU writes are masked
    assign mem_addr = busy ? cur_addr : cpu_addr;
    assign mem_wr   = busy ? (state == S_WR) : cpu_wr;
    assign mem_din  = busy ? DATA_W'({hi_byte, lo_byte}) : cpu_din;

endmodule

// File: tb/tb_mano_mem_loader.sv
// Directed bench for mano_mem_loader: port pass-through table plus hand-written load sequences.
module tb_mano_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [11:0] cpu_addr;
    logic        cpu_wr;
    logic [15:0] cpu_din;
    logic [11:0] mem_addr;
    logic        mem_wr;
    logic [15:0] mem_din;
    logic        busy;
    logic        done;
    logic [12:0] words_loaded;
`ifdef LOADER_CHECKSUM_EN
    logic        chk_err;
`endif

    mano_mem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .cpu_addr     (cpu_addr),
        .cpu_wr       (cpu_wr),
        .cpu_din      (cpu_din),
        .mem_addr     (mem_addr),
        .mem_wr       (mem_wr),
        .mem_din      (mem_din),
        .busy         (busy),
        .done         (done),
`ifdef LOADER_CHECKSUM_EN
        .chk_err      (chk_err),
`endif
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Memory model plus write-cycle observation
    logic [15:0] mem [4096];
    int          wr_cnt     = 0;
    int          ready_viol = 0;
    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr] <= mem_din;
            wr_cnt        <= wr_cnt + 1;
            if (busy && byte_ready) ready_viol <= ready_viol + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] bq[$];

    task automatic send_q(input int gap);
        int n;
        foreach (bq[i]) begin
            repeat (gap) @(negedge clk);
            byte_in    = bq[i];
            byte_valid = 1'b1;
            n = 0;
            while (!byte_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!byte_ready) check("byte_accept_timeout", 32'(byte_ready), 32'd1);
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [15:0] din;
        logic [11:0] exp_addr;
        logic        exp_wr;
        logic [15:0] exp_din;
    } pt_vec_t;

    pt_vec_t pt_tab [4];
    int      wr_base;

    initial begin
        pt_tab[0] = '{12'h7A0, 1'b0, 16'h0000, 12'h7A0, 1'b0, 16'h0000};
        pt_tab[1] = '{12'h7A1, 1'b1, 16'hBEEF, 12'h7A1, 1'b1, 16'hBEEF};
        pt_tab[2] = '{12'hFFF, 1'b1, 16'h5A5A, 12'hFFF, 1'b1, 16'h5A5A};
        pt_tab[3] = '{12'h001, 1'b0, 16'hFFFF, 12'h001, 1'b0, 16'hFFFF};

        rst_n = 1'b0; start = 1'b0; byte_in = '0; byte_valid = 1'b0;
        cpu_addr = '0; cpu_wr = 1'b0; cpu_din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);

        // Idle pass-through of the CPU port
        for (int i = 0; i < 4; i++) begin
            cpu_addr = pt_tab[i].addr; cpu_wr = pt_tab[i].wr; cpu_din = pt_tab[i].din;
            #1;
            check($sformatf("pt_addr[%0d]", i), 32'(mem_addr), 32'(pt_tab[i].exp_addr));
            check($sformatf("pt_wr[%0d]", i), 32'(mem_wr), 32'(pt_tab[i].exp_wr));
            check($sformatf("pt_din[%0d]", i), 32'(mem_din), 32'(pt_tab[i].exp_din));
            @(negedge clk);
        end
        cpu_wr = 1'b0;
        check("pt_mem_7a1", 32'(mem[12'h7A1]), 32'h0000BEEF);

        // Basic two-word load, back-to-back bytes
        wr_base = wr_cnt;
        pulse_start();
        check("ld1_busy", 32'(busy), 32'd1);
        check("ld1_ready", 32'(byte_ready), 32'd1);
        bq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_q(0);
        wait_done();
        check("ld1_mem010", 32'(mem[12'h010]), 32'h1234);
        check("ld1_mem011", 32'(mem[12'h011]), 32'hABCD);
        check("ld1_done", 32'(done), 32'd1);
        check("ld1_busy_end", 32'(busy), 32'd0);
        check("ld1_words", 32'(words_loaded), 32'd2);
        check("ld1_wrcnt", 32'(wr_cnt - wr_base), 32'd2);

        // Address wrap from 0xFFF to 0x000; start from DONE
        wr_base = wr_cnt;
        pulse_start();
        check("ld2_done_clr", 32'(done), 32'd0);
        check("ld2_words_clr", 32'(words_loaded), 32'd0);
        bq = '{8'h0F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
        send_q(0);
        wait_done();
        check("ld2_memfff", 32'(mem[12'hFFF]), 32'h1111);
        check("ld2_mem000", 32'(mem[12'h000]), 32'h2222);
        check("ld2_wrcnt", 32'(wr_cnt - wr_base), 32'd2);

        // Zero word count goes straight to the end without writing
        wr_base = wr_cnt;
        pulse_start();
        bq = '{8'h00, 8'h20, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        bq.push_back(8'h00);
`endif
        send_q(0);
        wait_done();
        check("ld3_done", 32'(done), 32'd1);
        check("ld3_words", 32'(words_loaded), 32'd0);
        check("ld3_wrcnt", 32'(wr_cnt - wr_base), 32'd0);

        // Gapped stream with the CPU hammering writes; the loader must mask them
        wr_base    = wr_cnt;
        ready_viol = 0;
        pulse_start();
        cpu_addr = 12'h123; cpu_din = 16'hDEAD; cpu_wr = 1'b1;
        bq = '{8'h00, 8'h00, 8'h00, 8'h03};
        send_q(5);
        #1;
        check("ld4_mask_wr", 32'(mem_wr), 32'd0);
        check("ld4_hold_addr", 32'(mem_addr), 32'h000);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`ifdef LOADER_CHECKSUM_EN
        bq.push_back(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06);
`endif
        send_q(5);
        wait_done();
        cpu_wr = 1'b0;
        check("ld4_mem000", 32'(mem[12'h000]), 32'h0102);
        check("ld4_mem001", 32'(mem[12'h001]), 32'h0304);
        check("ld4_mem002", 32'(mem[12'h002]), 32'h0506);
        check("ld4_wrcnt", 32'(wr_cnt - wr_base), 32'd3);
        check("ld4_ready_in_wr", 32'(ready_viol), 32'd0);
        check("ld4_words", 32'(words_loaded), 32'd3);

        // Reset mid-load after one data byte, with stray start pulses while busy
        wr_base = wr_cnt;
        pulse_start();
        bq = '{8'h00, 8'h05};
        send_q(0);
        pulse_start();
        bq = '{8'h00, 8'h01, 8'h55};
        send_q(0);
        check("ld5_busy_mid", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("ld5_rst_busy", 32'(busy), 32'd0);
        check("ld5_rst_ready", 32'(byte_ready), 32'd0);
        check("ld5_rst_words", 32'(words_loaded), 32'd0);
        check("ld5_rst_wrcnt", 32'(wr_cnt - wr_base), 32'd0);
        pulse_start();
        bq = '{8'h00, 8'h05, 8'h00, 8'h01, 8'h77};
        send_q(0);
        pulse_start();
        bq = '{8'h88};
`ifdef LOADER_CHECKSUM_EN
        bq.push_back(8'h77 ^ 8'h88);
`endif
        send_q(0);
        wait_done();
        check("ld5_mem005", 32'(mem[12'h005]), 32'h7788);
        check("ld5_words", 32'(words_loaded), 32'd1);
        check("ld5_wrcnt", 32'(wr_cnt - wr_base), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good, then bad
        pulse_start();
        bq = '{8'h00, 8'h30, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        send_q(0);
        wait_done();
        check("chk_good", 32'(chk_err), 32'd0);
        check("chk_mem030", 32'(mem[12'h030]), 32'h1234);
        pulse_start();
        bq = '{8'h00, 8'h30, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        send_q(0);
        wait_done();
        check("chk_bad", 32'(chk_err), 32'd1);
        pulse_start();
        check("chk_clr", 32'(chk_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
